reg_stacker: RTL and testbench

//  Hardware context save/restore engine sitting opposite the register file port set: it reads a

---
 rtl/reg_stacker.sv | 160 ++++++++++++++++
 tb/tb_reg_stacker.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_stacker.sv
// reg_stacker: hardware context save/restore engine.
//
// On push it reads the register window x[FirstReg] .. x[FirstReg+NumSaved-1]
// through the register file read port and stacks it as one frame in internal
// storage. On pop it writes the newest frame back through the write port.
// Frames nest up to StackDepth deep. A completed push pulses ra_set_o so the
// register file loads ra with its magic return value.
//
// Ports
//   clk_i        clock, all state on posedge
//   rst_i        asynchronous active-high reset
//   push_i       save request (level, sampled only when idle)
//   pop_i        restore request (level, sampled only when idle)
//   busy_o       high while saving, restoring or signalling done
//   done_o       one-cycle pulse, operation complete
//   overflow_o   one-cycle pulse, push refused because the stack is full
//   underflow_o  one-cycle pulse, pop refused because the stack is empty
//   depth_o      number of frames currently stored
//   rf_raddr_o   register file read address (valid while saving)
//   rf_rdata_i   combinational read data for rf_raddr_o
//   rf_waddr_o   register file write address (valid while restoring)
//   rf_wdata_o   register file write data
//   rf_we_o      register file write enable
//   ra_set_o     register file ra_set strobe (ra <= ~0)
//
// Handshake: push_i/pop_i are plain levels, not valid/ready. A request is
// taken on a rising edge only while idle; requests seen in any other state
// are dropped, not queued. The caller owns muxing rf_* with the pipeline and
// must keep the register file untouched while busy_o is high.
module reg_stacker #(
   parameter int FirstReg   = 10,
   parameter int NumSaved   = 8,
   parameter int StackDepth = 4
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              push_i,
   input  logic                              pop_i,
   output logic                              busy_o,
   output logic                              done_o,
   output logic                              overflow_o,
   output logic                              underflow_o,
   output logic [$clog2(StackDepth+1)-1:0]   depth_o,
   output logic [4:0]                        rf_raddr_o,
   input  logic [31:0]                       rf_rdata_i,
   output logic [4:0]                        rf_waddr_o,
   output logic [31:0]                       rf_wdata_o,
   output logic                              rf_we_o,
   output logic                              ra_set_o
);

   localparam int DepthW = $clog2(StackDepth + 1);
   localparam int Words  = StackDepth * NumSaved;
   localparam int IdxW   = (Words > 1) ? $clog2(Words) : 1;
   localparam int KW     = (NumSaved > 1) ? $clog2(NumSaved) : 1;

   localparam logic [KW-1:0]     KLast    = KW'(NumSaved - 1);
   localparam logic [DepthW-1:0] DepthMax = DepthW'(StackDepth);
   localparam logic [4:0]        BaseAddr = 5'(FirstReg);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SAVE    = 2'd1,
      ST_RESTORE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   state_t            state_q;
   logic [DepthW-1:0] sp_q;
   logic [KW-1:0]     k_q;
   logic              op_push_q;   // remembers which op is finishing in DONE
   logic              overflow_q;
   logic              underflow_q;

   logic [31:0]       mem_q [Words];
   logic [IdxW-1:0]   wr_idx;
   logic [IdxW-1:0]   rd_idx;

   // Frame n occupies words n*NumSaved .. n*NumSaved+NumSaved-1.
   // Saving fills frame sp; restoring drains frame sp-1 (sp>=1 there).
   assign wr_idx = IdxW'(sp_q) * IdxW'(NumSaved) + IdxW'(k_q);
   assign rd_idx = IdxW'(sp_q - DepthW'(1)) * IdxW'(NumSaved) + IdxW'(k_q);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         sp_q        <= '0;
         k_q         <= '0;
         op_push_q   <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               k_q <= '0;
               // push wins over a simultaneous pop
               if (push_i) begin
                  if (sp_q < DepthMax) begin
                     state_q   <= ST_SAVE;
                     op_push_q <= 1'b1;
                  end else begin
                     overflow_q <= 1'b1;
                  end
               end else if (pop_i) begin
                  if (sp_q != '0) begin
                     state_q   <= ST_RESTORE;
                     op_push_q <= 1'b0;
                  end else begin
                     underflow_q <= 1'b1;
                  end
               end
            end
            ST_SAVE: begin
               if (k_q == KLast) begin
                  k_q     <= '0;
                  sp_q    <= sp_q + DepthW'(1);
                  state_q <= ST_DONE;
               end else begin
                  k_q <= k_q + KW'(1);
               end
            end
            ST_RESTORE: begin
               if (k_q == KLast) begin
                  k_q     <= '0;
                  sp_q    <= sp_q - DepthW'(1);
                  state_q <= ST_DONE;
               end else begin
                  k_q <= k_q + KW'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Frame storage is deliberately not reset; a reset only forgets frames
   // by clearing sp.
   always_ff @(posedge clk_i) begin
      if (state_q == ST_SAVE) begin
         mem_q[wr_idx] <= rf_rdata_i;
      end
   end

   assign busy_o      = (state_q != ST_IDLE);
   assign done_o      = (state_q == ST_DONE);
   assign ra_set_o    = (state_q == ST_DONE) && op_push_q;
   assign overflow_o  = overflow_q;
   assign underflow_o = underflow_q;
   assign depth_o     = sp_q;

   assign rf_raddr_o  = (state_q == ST_SAVE)    ? (BaseAddr + 5'(k_q)) : 5'd0;
   assign rf_we_o     = (state_q == ST_RESTORE);
   assign rf_waddr_o  = (state_q == ST_RESTORE) ? (BaseAddr + 5'(k_q)) : 5'd0;
   assign rf_wdata_o  = (state_q == ST_RESTORE) ? mem_q[rd_idx]        : 32'd0;

endmodule

// File: tb/tb_reg_stacker.sv
// Directed testbench for reg_stacker with default parameters
// (window x10..x17, four frames). A small register file array feeds the
// read port; write-port traffic is compared against hand-computed values.
module tb_reg_stacker;

   logic        clk_i;
   logic        rst_i;
   logic        push_i;
   logic        pop_i;
   logic        busy_o;
   logic        done_o;
   logic        overflow_o;
   logic        underflow_o;
   logic [2:0]  depth_o;
   logic [4:0]  rf_raddr_o;
   logic [31:0] rf_rdata_i;
   logic [4:0]  rf_waddr_o;
   logic [31:0] rf_wdata_o;
   logic        rf_we_o;
   logic        ra_set_o;

   logic [31:0] rf [32];

   int n_checks;
   int n_fail;

   reg_stacker dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (push_i),
      .pop_i       (pop_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .overflow_o  (overflow_o),
      .underflow_o (underflow_o),
      .depth_o     (depth_o),
      .rf_raddr_o  (rf_raddr_o),
      .rf_rdata_i  (rf_rdata_i),
      .rf_waddr_o  (rf_waddr_o),
      .rf_wdata_o  (rf_wdata_o),
      .rf_we_o     (rf_we_o),
      .ra_set_o    (ra_set_o)
   );

   assign rf_rdata_i = rf[rf_raddr_o];

   // clock / reset
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic load_rf(input logic [31:0] base);
      for (int i = 0; i < 32; i++) rf[i] = 32'hDEAD0000 + 32'(i);
      for (int i = 0; i < 8; i++) rf[10+i] = base + 32'(i);
   endtask

   task automatic check_idle_outputs(input string tag, input logic [2:0] exp_depth);
      check({tag, "_busy"},  32'(busy_o), 32'd0);
      check({tag, "_done"},  32'(done_o), 32'd0);
      check({tag, "_raddr"}, 32'(rf_raddr_o), 32'd0);
      check({tag, "_we"},    32'(rf_we_o), 32'd0);
      check({tag, "_waddr"}, 32'(rf_waddr_o), 32'd0);
      check({tag, "_wdata"}, rf_wdata_o, 32'd0);
      check({tag, "_raset"}, 32'(ra_set_o), 32'd0);
      check({tag, "_ovf"},   32'(overflow_o), 32'd0);
      check({tag, "_unf"},   32'(underflow_o), 32'd0);
      check({tag, "_depth"}, 32'(depth_o), 32'(exp_depth));
   endtask

   // Called at a negedge while idle; returns at the negedge after DONE.
   task automatic do_push(input string tag, input logic also_pop, input logic [2:0] exp_depth);
      push_i = 1'b1;
      pop_i  = also_pop;
      @(negedge clk_i);
      push_i = 1'b0;
      pop_i  = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check({tag, "_save_busy"},  32'(busy_o), 32'd1);
         check({tag, "_save_raddr"}, 32'(rf_raddr_o), 32'(10 + i));
         check({tag, "_save_we"},    32'(rf_we_o), 32'd0);
         check({tag, "_save_done"},  32'(done_o), 32'd0);
         @(negedge clk_i);
      end
      check({tag, "_done"},       32'(done_o), 32'd1);
      check({tag, "_done_raset"}, 32'(ra_set_o), 32'd1);
      check({tag, "_done_busy"},  32'(busy_o), 32'd1);
      check({tag, "_done_depth"}, 32'(depth_o), 32'(exp_depth));
      check({tag, "_done_we"},    32'(rf_we_o), 32'd0);
      @(negedge clk_i);
      check_idle_outputs({tag, "_after"}, exp_depth);
   endtask

   task automatic do_pop(input string tag, input logic [31:0] base, input logic [2:0] exp_depth);
      pop_i = 1'b1;
      @(negedge clk_i);
      pop_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check({tag, "_rest_we"},    32'(rf_we_o), 32'd1);
         check({tag, "_rest_waddr"}, 32'(rf_waddr_o), 32'(10 + i));
         check({tag, "_rest_wdata"}, rf_wdata_o, base + 32'(i));
         check({tag, "_rest_raddr"}, 32'(rf_raddr_o), 32'd0);
         check({tag, "_rest_busy"},  32'(busy_o), 32'd1);
         @(negedge clk_i);
      end
      check({tag, "_done"},       32'(done_o), 32'd1);
      check({tag, "_done_raset"}, 32'(ra_set_o), 32'd0);
      check({tag, "_done_depth"}, 32'(depth_o), 32'(exp_depth));
      check({tag, "_done_we"},    32'(rf_we_o), 32'd0);
      @(negedge clk_i);
      check_idle_outputs({tag, "_after"}, exp_depth);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      push_i   = 1'b0;
      pop_i    = 1'b0;
      rst_i    = 1'b1;
      load_rf(32'h0);
      #1;
      check_idle_outputs("reset", 3'd0);
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      check_idle_outputs("post_reset", 3'd0);

      // single push of 0xA0..0xA7, clobber, then restore
      load_rf(32'hA0);
      do_push("push1", 1'b0, 3'd1);
      load_rf(32'hF0);
      do_pop("pop1", 32'hA0, 3'd0);

      // fill the stack, overflow, drain in LIFO order, underflow
      load_rf(32'h10); do_push("fill1", 1'b0, 3'd1);
      load_rf(32'h20); do_push("fill2", 1'b0, 3'd2);
      load_rf(32'h30); do_push("fill3", 1'b0, 3'd3);
      load_rf(32'h40); do_push("fill4", 1'b0, 3'd4);
      push_i = 1'b1;
      @(negedge clk_i);
      push_i = 1'b0;
      check("ovf_pulse", 32'(overflow_o), 32'd1);
      check("ovf_busy",  32'(busy_o), 32'd0);
      check("ovf_depth", 32'(depth_o), 32'd4);
      @(negedge clk_i);
      check_idle_outputs("ovf_after", 3'd4);
      load_rf(32'hEE);
      do_pop("drain4", 32'h40, 3'd3);
      do_pop("drain3", 32'h30, 3'd2);
      do_pop("drain2", 32'h20, 3'd1);
      do_pop("drain1", 32'h10, 3'd0);
      pop_i = 1'b1;
      @(negedge clk_i);
      pop_i = 1'b0;
      check("unf_pulse", 32'(underflow_o), 32'd1);
      check("unf_busy",  32'(busy_o), 32'd0);
      @(negedge clk_i);
      check_idle_outputs("unf_after", 3'd0);

      // push and pop together: push wins
      load_rf(32'h50); do_push("pp_pre", 1'b0, 3'd1);
      load_rf(32'h60); do_push("pp_both", 1'b1, 3'd2);
      do_pop("pp_pop2", 32'h60, 3'd1);
      do_pop("pp_pop1", 32'h50, 3'd0);

      // asynchronous reset in SAVE cycle 4
      load_rf(32'h70);
      push_i = 1'b1;
      @(negedge clk_i);
      push_i = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i);
      @(negedge clk_i);
      check("rst_save_raddr", 32'(rf_raddr_o), 32'd13);
      check("rst_save_busy",  32'(busy_o), 32'd1);
      #1;
      rst_i = 1'b1;
      #1;
      check_idle_outputs("rst_mid", 3'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      check_idle_outputs("rst_release", 3'd0);
      pop_i = 1'b1;
      @(negedge clk_i);
      pop_i = 1'b0;
      check("rst_unf_pulse", 32'(underflow_o), 32'd1);
      check("rst_unf_busy",  32'(busy_o), 32'd0);
      check("rst_unf_we",    32'(rf_we_o), 32'd0);
      @(negedge clk_i);
      check_idle_outputs("rst_unf_after", 3'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
